// File: rtl/reduction_seq.sv
// Vector-reduce sequencer for the byte-sum reduction unit.
// The sequencer reads consecutive register pairs from the register file and
// registers each pair onto the reduction unit operands. It then accumulates
// the low 10 bits of every per-pair result into a 16-bit total.
//
// state | meaning
// IDLE  | waiting for start; addresses and operands hold their last values
// RUN   | issue one register pair per cycle to the reduction unit
// DRAIN | fold the last issued pair into the accumulator, load result
// DONE  | done pulse; result valid; start ignored
module reduction_seq #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_pairs,
  output logic [ADDR_W-1:0] rf_addr_a,
  output logic [ADDR_W-1:0] rf_addr_b,
  input  logic [15:0]       rf_data_a,
  input  logic [15:0]       rf_data_b,
  output logic [15:0]       ru_a,
  output logic [15:0]       ru_b,
  input  logic [15:0]       ru_s,
  output logic              busy,
  output logic              done,
  output logic [15:0]       result
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] rf_addr_a_q, rf_addr_b_q;
  logic [15:0]       ru_a_q, ru_b_q;
  logic [15:0]       acc_q, acc_d;
  logic [15:0]       result_q;
  logic              pipe_v_q;
  logic              busy_q, done_q;

  // Accumulate stage: bits 15:10 of ru_s are sign-extension artefacts, so
  // only the unsigned byte sum in bits 9:0 is added.
  always_comb begin
    acc_d = acc_q;
    if (pipe_v_q) acc_d = acc_q + {6'b0, ru_s[9:0]};
  end

  // Sequencer FSM with registered outputs; the result is loaded on entry to
  // DONE so that it is visible together with the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      rf_addr_a_q <= '0;
      rf_addr_b_q <= '0;
      ru_a_q      <= '0;
      ru_b_q      <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      pipe_v_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      acc_q  <= acc_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            acc_q  <= '0;
            if (num_pairs != '0) begin
              ptr_q       <= base_addr;
              cnt_q       <= num_pairs;
              rf_addr_a_q <= base_addr;
              rf_addr_b_q <= base_addr + ADDR_W'(1);
              state_q     <= RUN;
            end else begin
              result_q <= '0;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        RUN: begin
          ru_a_q   <= rf_data_a;
          ru_b_q   <= rf_data_b;
          pipe_v_q <= 1'b1;
          ptr_q    <= ptr_q + ADDR_W'(2);
          cnt_q    <= cnt_q - ADDR_W'(1);
          if (cnt_q == ADDR_W'(1)) begin
            state_q <= DRAIN;
          end else begin
            rf_addr_a_q <= ptr_q + ADDR_W'(2);
            rf_addr_b_q <= ptr_q + ADDR_W'(3);
          end
        end
        DRAIN: begin
          pipe_v_q <= 1'b0;
          result_q <= acc_d;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rf_addr_a = rf_addr_a_q;
  assign rf_addr_b = rf_addr_b_q;
  assign ru_a      = ru_a_q;
  assign ru_b      = ru_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;

endmodule

// File: doc/reduction_seq.md
Name: reduction_seq

Overview:
- Multi-cycle sequencer for the byte-sum reduction unit.
- Walks a contiguous run of register pairs in the register file and drives each pair onto the reduction unit's A/B operands.
- Accumulates the per-pair byte sums into one 16-bit total.
- Sits beside the register file read ports and implements the vector-reduce instruction; start/busy/done handshake with the control unit.

Parameters:
- ADDR_W, 4, register file address width; legal range 2..6, which guarantees the 16-bit accumulator cannot overflow (63 x 1020 < 65536).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- base_addr  in  ADDR_W  register address of the first A operand
- num_pairs  in  ADDR_W  number of register pairs to reduce; 0 is legal
- rf_addr_a  out  ADDR_W  register file read address, port A
- rf_addr_b  out  ADDR_W  register file read address, port B
- rf_data_a  in  16  port A read data, combinational from rf_addr_a
- rf_data_b  in  16  port B read data, combinational from rf_addr_b
- ru_a  out  16  reduction unit operand A, registered
- ru_b  out  16  reduction unit operand B, registered
- ru_s  in  16  reduction unit result, combinational from ru_a/ru_b
- busy  out  1  high from the cycle after start is accepted until the done cycle, inclusive
- done  out  1  one-cycle pulse; result valid
- result  out  16  accumulated sum; held until the next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0 (rf_addr_a/b, ru_a/b, busy, done, result); internal pointer, count, accumulator and pipe-valid all 0. Reset mid-operation abandons the run with no done pulse.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 with num_pairs!=0: latch ptr=base_addr, cnt=num_pairs, clear acc, go RUN.
  - start=1 with num_pairs=0: clear acc, go DONE.
  - start=0: stay in IDLE; rf_addr outputs hold their last values.
- RUN, cycle k (k=0..cnt-1):
  - rf_addr_a=ptr, rf_addr_b=ptr+1.
  - Register ru_a<=rf_data_a, ru_b<=rf_data_b; set pipe-valid.
  - ptr<=ptr+2 (mod 2^ADDR_W, wrap allowed); decrement remaining count.
  - Go DRAIN after issuing the last pair.
- Accumulate stage, every cycle pipe-valid is set:
  - acc <= acc + {6'b0, ru_s[9:0]}.
  - ru_s bits 15:10 are sign-extension artefacts of the reduction unit and are ignored; the byte sum is unsigned, 0..1020.
  - One pair issues per cycle; accumulation trails issue by one cycle.
- DRAIN (1 cycle): accumulates the final pair; clear pipe-valid; go DONE.
- DONE (1 cycle): result<=acc value including all pairs, visible the same cycle; done=1; go IDLE.
- Latency: start accepted at cycle 0 -> done at cycle N+2 for N>=1; at cycle 1 for N=0.
- Handshake: busy=1 in RUN/DRAIN/DONE. start is ignored outside IDLE, including in the DONE cycle; the next start is accepted the cycle after done.
- ru_a/ru_b hold their last operands outside RUN.
- base_addr and num_pairs are sampled only at acceptance; later changes have no effect on the run.

Test Plan:
- Single pair: R2=0x0102, R3=0x0304; base=2, num=1 -> ru_a=0x0102, ru_b=0x0304; result=0x000A; done at cycle 3; busy high cycles 1-3.
- Sign-artefact check: R0=R1=0xFFFF, num=1 -> ru_s=0xFFFC, result must be 0x03FC, not 0xFFFC.
- Multi-pair: R0..R5=0xFFFF; base=0, num=3 -> result=0x0BF4 (3060); one RUN cycle per pair; done at cycle 5.
- Wrap: ADDR_W=4, base=14, num=2 -> addresses (14,15) then (0,1); with R14=R15=0x0101, R0=R1=0x0202, result=0x000C.
- Zero count: num=0 -> no RUN; done at cycle 1; result=0x0000. A start pulsed during a 3-pair run is ignored; the following start after done is accepted.
- Reset mid-run: assert rst_n=0 during RUN -> all outputs 0 immediately, no done pulse; a new start after release completes normally.
